// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Initiator side of the RAM_2_16x32 memory port. Takes single load/store requests from the
//   CPU datapath on a valid/ready handshake and sequences the RAM strobes with one cycle of
//   address/data setup before the strobe and one cycle of hold after it. A load captures
//   ram_data_output on the edge that ends the strobe. Every access ends with a one-cycle
//   rsp_valid pulse in the HOLD state.
//
//   FSM: IDLE -> SETUP -> STROBE (STROBE_CYCLES cycles) -> HOLD -> IDLE
//
//   Optional build macro RAM_ACCESS_ADDR_CHECK_EN: requests with req_addr >= DEPTH are still
//   accepted and timed like a normal access, but they never strobe the RAM, leave
//   ram_address/ram_data_input/rsp_rdata untouched, and finish with rsp_err=1. With the
//   macro undefined there is no range check and rsp_err is always 0.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake; req_ready is high only in IDLE
//   req_we              1 = store, 0 = load
//   req_addr/req_wdata  word address and store data
//   rsp_valid           one-cycle completion pulse (loads and stores)
//   rsp_rdata           last load data, held until the next successful load
//   rsp_err             address out of range, qualified by rsp_valid
//   busy                high in every state except IDLE
//   ram_*               RAM strobes, address, write data and read data
//   All outputs are registered.

module ram_access_ctrl #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned DEPTH         = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_input,
    input  logic [DATA_W-1:0] ram_data_output
);

    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15 || DEPTH == 0) begin : gen_bad_param
        $error("ram_access_ctrl: STROBE_CYCLES must be 1..15 and DEPTH non-zero");
    end

    // The counter runs STROBE_CYCLES-1 down to 0; STROBE ends when it reads 0.
    localparam logic [3:0] StrobeLoad = 4'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              ok_q, ok_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_re_q, ram_re_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              req_in_range;

`ifdef RAM_ACCESS_ADDR_CHECK_EN
    assign req_in_range = (64'(req_addr) < 64'(DEPTH));
`else
    assign req_in_range = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        ok_d        = ok_q;
        rsp_rdata_d = rsp_rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    ok_d    = req_in_range;
                    state_d = StSetup;
                    // Out-of-range requests leave the RAM-facing bus untouched.
                    if (req_in_range) begin
                        ram_addr_d = req_addr;
                        if (req_we) begin
                            ram_din_d = req_wdata;
                        end
                    end
                end
            end
            StSetup: begin
                cnt_d   = StrobeLoad;
                state_d = StStrobe;
            end
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHold;
                    // Read data is sampled while read_enable is still high.
                    if (!we_q && ok_q) begin
                        rsp_rdata_d = ram_data_output;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they are registered yet state-aligned.
        req_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        ram_we_d    = (state_d == StStrobe) && we_d && ok_d;
        ram_re_d    = (state_d == StStrobe) && !we_d && ok_d;
        rsp_valid_d = (state_d == StHold);
        rsp_err_d   = (state_d == StHold) && !ok_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            ok_q        <= 1'b1;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            ok_q        <= ok_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign busy             = busy_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_err          = rsp_err_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign ram_write_enable = ram_we_q;
    assign ram_read_enable  = ram_re_q;
    assign ram_address      = ram_addr_q;
    assign ram_data_input   = ram_din_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl. Two instances: u_dut0 (STROBE_CYCLES=1, DEPTH=1024) and
// u_dut1 (STROBE_CYCLES=3, DEPTH=65536), each attached to a simple RAM with combinational
// read and write on the rising edge.

module tb_ram_access_ctrl;

    localparam int unsigned S0 = 1;
    localparam int unsigned S1 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic        busy      [2];
    logic        ram_we    [2];
    logic        ram_re    [2];
    logic [31:0] rsp_rdata [2];
    logic [15:0] ram_addr  [2];
    logic [31:0] ram_din   [2];
    logic [31:0] ram_dout  [2];

    logic [31:0] mem0 [65536];
    logic [31:0] mem1 [65536];

    always @(posedge clk) begin
        if (ram_we[0]) mem0[ram_addr[0]] <= ram_din[0];
        if (ram_we[1]) mem1[ram_addr[1]] <= ram_din[1];
    end
    assign ram_dout[0] = ram_re[0] ? mem0[ram_addr[0]] : 32'h0;
    assign ram_dout[1] = ram_re[1] ? mem1[ram_addr[1]] : 32'h0;

    ram_access_ctrl #(.ADDR_W(16), .DATA_W(32), .STROBE_CYCLES(S0), .DEPTH(1024)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .busy(busy[0]),
        .ram_write_enable(ram_we[0]), .ram_read_enable(ram_re[0]),
        .ram_address(ram_addr[0]), .ram_data_input(ram_din[0]),
        .ram_data_output(ram_dout[0])
    );

    ram_access_ctrl #(.ADDR_W(16), .DATA_W(32), .STROBE_CYCLES(S1), .DEPTH(65536)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .busy(busy[1]),
        .ram_write_enable(ram_we[1]), .ram_read_enable(ram_re[1]),
        .ram_address(ram_addr[1]), .ram_data_input(ram_din[1]),
        .ram_data_output(ram_dout[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Drives a request, waits for acceptance, then watches the whole
    // access (SETUP..HOLD) plus the following IDLE cycle. With hold=1 req_valid stays high
    // and the next request payload is presented right after acceptance.
    task automatic access(input int idx, input logic we, input logic [15:0] addr,
                          input logic [31:0] wd, input logic [15:0] exp_addr,
                          input logic [31:0] exp_din, input int exp_stb, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic hold, input logic nwe,
                          input logic [15:0] naddr, input logic [31:0] nwd);
        int s, wait_n, we_n, re_n, both_n, ready_hi, busy_lo, bus_bad, vld_n, vld_pos;
        logic        err_at;
        logic [31:0] rdata_at;
        s = (idx == 1) ? int'(S1) : int'(S0);
        wait_n = 0; we_n = 0; re_n = 0; both_n = 0; ready_hi = 0; busy_lo = 0;
        bus_bad = 0; vld_n = 0; vld_pos = 0; err_at = 1'b0; rdata_at = 32'h0;
        req_valid[idx] = 1'b1;
        req_we[idx]    = we;
        req_addr[idx]  = addr;
        req_wdata[idx] = wd;
        while (!req_ready[idx] && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("accept_in_time", 32'(wait_n < 50), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            req_we[idx]    = nwe;
            req_addr[idx]  = naddr;
            req_wdata[idx] = nwd;
        end else begin
            req_valid[idx] = 1'b0;
        end
        for (int k = 1; k <= s + 2; k++) begin
            if (k > 1) @(negedge clk);
            if (ram_we[idx]) we_n++;
            if (ram_re[idx]) re_n++;
            if (ram_we[idx] && ram_re[idx]) both_n++;
            if (req_ready[idx]) ready_hi++;
            if (!busy[idx]) busy_lo++;
            if (ram_addr[idx] !== exp_addr || ram_din[idx] !== exp_din) bus_bad++;
            if (rsp_valid[idx]) begin
                vld_n++;
                vld_pos  = k;
                err_at   = rsp_err[idx];
                rdata_at = rsp_rdata[idx];
            end
        end
        check("write_strobe_cycles", 32'(we_n), we ? 32'(exp_stb) : 32'd0);
        check("read_strobe_cycles", 32'(re_n), we ? 32'd0 : 32'(exp_stb));
        check("strobes_overlap", 32'(both_n), 32'd0);
        check("ready_while_busy", 32'(ready_hi), 32'd0);
        check("busy_low_in_access", 32'(busy_lo), 32'd0);
        check("bus_not_stable", 32'(bus_bad), 32'd0);
        check("rsp_valid_count", 32'(vld_n), 32'd1);
        check("rsp_valid_latency", 32'(vld_pos), 32'(s + 2));
        check("rsp_err", 32'(err_at), 32'(exp_err));
        check("rsp_rdata", rdata_at, exp_rdata);
        @(negedge clk);
        check("ready_after_access", 32'(req_ready[idx]), 32'd1);
        check("rsp_valid_after", 32'(rsp_valid[idx]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 16'h0;
            req_wdata[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_req_ready", 32'(req_ready[i]), 32'd1);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
            check("rst_strobes", {30'd0, ram_we[i], ram_re[i]}, 32'd0);
            check("rst_ram_address", 32'(ram_addr[i]), 32'd0);
            check("rst_ram_data_input", ram_din[i], 32'd0);
            check("rst_rsp_rdata", rsp_rdata[i], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Store 66 <- 20, then load it back.
        access(0, 1'b1, 16'd66, 32'd20, 16'd66, 32'd20, S0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0);
        access(0, 1'b0, 16'd66, 32'd0, 16'd66, 32'd20, S0, 1'b0, 32'd20, 1'b0, 1'b0, 16'd0, 32'd0);

        // Store 55 <- 1, then back-to-back loads 55 and 66 with req_valid held.
        access(0, 1'b1, 16'd55, 32'd1, 16'd55, 32'd1, S0, 1'b0, 32'd20, 1'b0, 1'b0, 16'd0, 32'd0);
        access(0, 1'b0, 16'd55, 32'd0, 16'd55, 32'd1, S0, 1'b0, 32'd1, 1'b1, 1'b0, 16'd66, 32'd0);
        access(0, 1'b0, 16'd66, 32'd0, 16'd66, 32'd1, S0, 1'b0, 32'd20, 1'b0, 1'b0, 16'd0, 32'd0);

        // STROBE_CYCLES=3: preload FFFF, load it, then a store must not touch rsp_rdata.
        access(1, 1'b1, 16'hFFFF, 32'hCAFEF00D, 16'hFFFF, 32'hCAFEF00D, S1, 1'b0, 32'd0,
               1'b0, 1'b0, 16'd0, 32'd0);
        access(1, 1'b0, 16'hFFFF, 32'd0, 16'hFFFF, 32'hCAFEF00D, S1, 1'b0, 32'hCAFEF00D,
               1'b0, 1'b0, 16'd0, 32'd0);
        access(1, 1'b1, 16'h0010, 32'd5, 16'h0010, 32'd5, S1, 1'b0, 32'hCAFEF00D,
               1'b0, 1'b0, 16'd0, 32'd0);

        // Reset in the middle of the strobe of a store 66 <- DEAD.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 16'd66;
        req_wdata[0] = 32'hDEAD;
        check("rst_test_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("rst_test_setup_din", ram_din[0], 32'hDEAD);
        @(negedge clk);
        check("rst_test_strobe_on", 32'(ram_we[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_strobes", {30'd0, ram_we[0], ram_re[0]}, 32'd0);
        check("async_rst_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("post_rst_busy", 32'(busy[0]), 32'd0);
        check("post_rst_rdata", rsp_rdata[0], 32'd0);
        access(0, 1'b0, 16'd66, 32'd0, 16'd66, 32'd0, S0, 1'b0, 32'd20, 1'b0, 1'b0, 16'd0, 32'd0);

        // Store to 2000 on the DEPTH=1024 instance.
`ifdef RAM_ACCESS_ADDR_CHECK_EN
        access(0, 1'b1, 16'd2000, 32'h77, 16'd66, 32'd0, 0, 1'b1, 32'd20, 1'b0, 1'b0, 16'd0, 32'd0);
        access(0, 1'b0, 16'd66, 32'd0, 16'd66, 32'd0, S0, 1'b0, 32'd20, 1'b0, 1'b0, 16'd0, 32'd0);
`else
        access(0, 1'b1, 16'd2000, 32'h77, 16'd2000, 32'h77, S0, 1'b0, 32'd20,
               1'b0, 1'b0, 16'd0, 32'd0);
        access(0, 1'b0, 16'd2000, 32'd0, 16'd2000, 32'h77, S0, 1'b0, 32'h77,
               1'b0, 1'b0, 16'd0, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
